reverb_template_s2m_fifo_fir: RTL and testbench

Stream-to-memory FIFO for the FIR datapath. It accepts 32-bit samples from an Avalon-ST source, such as the FIR filter output, and buffers them in an internal register-based FIFO. The CPU drains them through an Avalon-MM read slave. Word 0 pops one sample; word 1 returns fill status. It is the read-back companion of the memory-to-stream FIFO that feeds the filter.

---
 rtl/reverb_template_s2m_fifo_fir.sv | 82 ++++++++
 tb/tb_reverb_template_s2m_fifo_fir.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reverb_template_s2m_fifo_fir.sv
// Stream-to-memory FIFO: Avalon-ST sink fills a register FIFO, and an
// Avalon-MM read slave drains it (word 0 pops one sample, word 1 is status).
module reverb_template_s2m_fifo_fir #(
  parameter int DEPTH   = 32,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic        rdclock,
  input  logic        reset_n,
  input  logic [31:0] avalonst_sink_data,
  input  logic        avalonst_sink_valid,
  output logic        avalonst_sink_ready,
  input  logic        avalonmm_read_slave_address,
  input  logic        avalonmm_read_slave_read,
  output logic [31:0] avalonmm_read_slave_readdata,
  output logic        avalonmm_read_slave_waitrequest
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][31:0] mem_q;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]     level_q, level_d;

  logic        full, empty, push, pop, data_rd;
  logic [31:0] status;

  // Flags come only from the registered level, so ready never depends on valid.
  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign data_rd = avalonmm_read_slave_read & ~avalonmm_read_slave_address;

  assign avalonst_sink_ready = reset_n & ~full;
  assign push = avalonst_sink_valid & avalonst_sink_ready;
  // A data read on an empty FIFO stalls instead of popping.
  assign pop  = reset_n & data_rd & ~empty;

  // Status word: full in bit 31, empty in bit 30, level in the low bits.
  always_comb begin
    status              = '0;
    status[31]          = full;
    status[30]          = empty;
    status[LEVEL_W-1:0] = level_q;
  end

  // Zero-latency read path: data word is the head of the FIFO, unregistered.
  assign avalonmm_read_slave_readdata    = avalonmm_read_slave_address ? status : mem_q[rd_ptr_q];
  assign avalonmm_read_slave_waitrequest = ~reset_n | (data_rd & empty);

  // Next-state for pointers and fill level; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; reset discards all buffered samples.
  always_ff @(posedge rdclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage is never cleared; the level alone says what is valid.
  always_ff @(posedge rdclock) begin
    if (push) mem_q[wr_ptr_q] <= avalonst_sink_data;
  end

endmodule

// File: tb/tb_reverb_template_s2m_fifo_fir.sv
// Directed bench for the stream-to-memory FIFO.
module tb_reverb_template_s2m_fifo_fir;

  logic        rdclock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] sdata   = '0;
  logic        svalid  = 1'b0;
  logic        sready;
  logic        addr    = 1'b0;
  logic        rd      = 1'b0;
  logic [31:0] rdata;
  logic        wreq;

  int n_tests = 0;
  int n_fail  = 0;

  reverb_template_s2m_fifo_fir #(.DEPTH(32)) dut (
    .rdclock                         (rdclock),
    .reset_n                         (reset_n),
    .avalonst_sink_data              (sdata),
    .avalonst_sink_valid             (svalid),
    .avalonst_sink_ready             (sready),
    .avalonmm_read_slave_address     (addr),
    .avalonmm_read_slave_read        (rd),
    .avalonmm_read_slave_readdata    (rdata),
    .avalonmm_read_slave_waitrequest (wreq)
  );

  always #5 rdclock = ~rdclock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic step();
    @(posedge rdclock);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    svalid = 1'b1; sdata = d;
    #1 chk("push_ready", 32'(sready), 32'd1);
    step();
    svalid = 1'b0;
  endtask

  task automatic pop_exp(input string tag, input logic [31:0] exp);
    addr = 1'b0; rd = 1'b1;
    #1 chk({tag, "_wreq"}, 32'(wreq), 32'd0);
    chk(tag, rdata, exp);
    step();
    rd = 1'b0;
  endtask

  task automatic stat_exp(input string tag, input logic [31:0] exp);
    addr = 1'b1; rd = 1'b1;
    #1 chk({tag, "_wreq"}, 32'(wreq), 32'd0);
    chk(tag, rdata, exp);
    step();
    rd = 1'b0; addr = 1'b0;
  endtask

  initial begin
    int acc, first_block;
    logic [31:0] q[$];
    logic [31:0] e;

    // Reset held with valid and read asserted.
    svalid = 1'b1; rd = 1'b1; addr = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rst_ready", 32'(sready), 32'd0);
      chk("rst_wreq", 32'(wreq), 32'd1);
      step();
    end
    reset_n = 1'b1; svalid = 1'b0; rd = 1'b0;
    stat_exp("post_rst_status", 32'h4000_0000);

    // Ordered drain.
    push(32'h11); push(32'h22); push(32'h33);
    pop_exp("drain0", 32'h11);
    pop_exp("drain1", 32'h22);
    pop_exp("drain2", 32'h33);
    stat_exp("drain_status", 32'h4000_0000);

    // Fill and backpressure.
    acc = 0; first_block = -1;
    svalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sdata = 32'(acc);
      #1;
      if (sready) acc++;
      else if (first_block < 0) first_block = i;
      step();
    end
    svalid = 1'b0;
    chk("fill_accepted", 32'(acc), 32'd32);
    chk("fill_first_block", 32'(first_block), 32'd32);
    stat_exp("fill_status", 32'h8000_0020);
    addr = 1'b0; rd = 1'b1;
    #1 chk("full_pop_wreq", 32'(wreq), 32'd0);
    chk("full_pop_data", rdata, 32'd0);
    chk("full_pop_ready_same", 32'(sready), 32'd0);
    step();
    rd = 1'b0;
    #1 chk("full_ready_recover", 32'(sready), 32'd1);
    push(32'd32);
    stat_exp("refill_status", 32'h8000_0020);
    for (int i = 1; i <= 32; i++) pop_exp("refill_drain", 32'(i));

    // Blocking read on empty.
    addr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1 chk("block_wreq", 32'(wreq), 32'd1);
      step();
    end
    svalid = 1'b1; sdata = 32'hDEAD_BEEF;
    #1 chk("block_wreq_push", 32'(wreq), 32'd1);
    step();
    svalid = 1'b0;
    #1 chk("block_done_wreq", 32'(wreq), 32'd0);
    chk("block_data", rdata, 32'hDEAD_BEEF);
    step();
    rd = 1'b0;
    stat_exp("block_status", 32'h4000_0000);

    // Concurrent push/pop across pointer wraps.
    for (int i = 0; i < 5; i++) begin
      push(32'(100 + i));
      q.push_back(32'(100 + i));
    end
    for (int i = 0; i < 100; i++) begin
      svalid = 1'b1; sdata = 32'(200 + i);
      addr = 1'b0; rd = 1'b1;
      e = q.pop_front();
      q.push_back(32'(200 + i));
      #1 chk("cc_wreq", 32'(wreq), 32'd0);
      chk("cc_ready", 32'(sready), 32'd1);
      chk("cc_data", rdata, e);
      step();
    end
    svalid = 1'b0; rd = 1'b0;
    stat_exp("cc_status", 32'h0000_0005);
    while (q.size() > 0) begin
      e = q.pop_front();
      pop_exp("cc_tail", e);
    end

    // Reset mid-operation.
    for (int i = 0; i < 7; i++) push(32'(300 + i));
    stat_exp("pre_rst_status", 32'h0000_0007);
    addr = 1'b0; rd = 1'b1; reset_n = 1'b0;
    #1 chk("mid_rst_ready", 32'(sready), 32'd0);
    chk("mid_rst_wreq", 32'(wreq), 32'd1);
    step();
    reset_n = 1'b1; rd = 1'b0;
    stat_exp("mid_rst_status", 32'h4000_0000);
    push(32'h5A5A_5A5A);
    pop_exp("mid_rst_fresh", 32'h5A5A_5A5A);
    stat_exp("final_status", 32'h4000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
